dff_16b: RTL and testbench

DFF_16B -- requirements
Module: dff_16b

---
 rtl/dff_16b_pkg.sv | 13 +
 rtl/dff_16b_cell.sv | 36 +++
 rtl/dff_16b.sv | 41 ++++
 tb/tb_dff_16b.sv | 114 +++++++++++
 4 files changed

// File: rtl/dff_16b_pkg.sv
// Shared project constants for the 16-bit enabled data register.
package dff_16b_pkg;

    // Default data width of the register.
    localparam int DATA_W = 16;

    // Default value forced onto the register output while reset is held.
    localparam logic [DATA_W-1:0] DATA_RST = '0;

    // Upper bound on the supported register width.
    localparam int DATA_W_MAX = 64;

endpackage : dff_16b_pkg

// File: rtl/dff_16b_cell.sv
// Single-bit storage cell.
// It has an asynchronous active-low reset, a load enable, and its own
// reset value. The top-level register is built from these cells.
module dff_cell #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    input  logic en_i,
    output logic q_o
);

    logic q_q;
    logic q_d;

    // Next-state select: load the new bit when enabled, otherwise recirculate.
    always_comb begin
        q_d = q_q;
        if (en_i) begin
            q_d = d_i;
        end
    end

    // State flop. The reset value appears as soon as rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= RESET_BIT;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule : dff_cell

// File: rtl/dff_16b.sv
// WIDTH-bit data register with a load enable and an asynchronous active-low
// reset. The register is one dff_cell per bit, and every cell shares the same
// enable, so the whole word loads and holds together. The output comes
// straight from the flops. Reset release must already be synchronised to clk
// before it reaches this block.
module dff_16b
    import dff_16b_pkg::*;
#(
    parameter int                WIDTH       = DATA_W,
    parameter logic [WIDTH-1:0]  RESET_VALUE = WIDTH'(DATA_RST)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data,
    input  logic             DFF_enable,
    output logic [WIDTH-1:0] out
);

    // Widths outside 1..DATA_W_MAX are not supported. This constant lets a
    // reader confirm the range check at elaboration.
    localparam bit WidthLegal = (WIDTH >= 1) && (WIDTH <= DATA_W_MAX);

    logic [WIDTH-1:0] out_q;

    // One cell per bit. Bit i of data feeds bit i of out, so the bit order
    // is preserved.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_cell #(
            .RESET_BIT (RESET_VALUE[i])
        ) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .d_i   (data[i]),
            .en_i  (DFF_enable),
            .q_o   (out_q[i])
        );
    end : g_bit

    assign out = out_q;

endmodule : dff_16b

// File: tb/tb_dff_16b.sv
// Directed and randomised self-checking bench for dff_16b.
module tb_dff_16b;
    import dff_16b_pkg::*;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] data;
    logic              DFF_enable;
    logic [DATA_W-1:0] out;

    int errors = 0;
    int checks = 0;
    logic [DATA_W-1:0] expOut;

    dff_16b #(
        .WIDTH       (DATA_W),
        .RESET_VALUE (16'h0000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data       (data),
        .DFF_enable (DFF_enable),
        .out        (out)
    );

    // 20-unit clock period. Rising edges occur at 10, 30, 50, ...
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Move to an absolute time in the directed timeline.
    task automatic waitUntil(input longint t);
        if (longint'($time) < t) #(t - longint'($time));
    endtask

    // Compare the DUT output against the value expected by the bench.
    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] expected);
        checks++;
        assert (out === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s at t=%0t: out=%0d expected=%0d", tag, $time, out, expected);
        end
    endtask

    // Directed timeline followed by a randomised run against a small model.
    initial begin
        rst_n      = 1'b0;
        data       = '0;
        DFF_enable = 1'b0;

        // Reset is held from time 0.
        waitUntil(1);   checkOutput("resetAt1",        16'd0);
        waitUntil(15);  checkOutput("resetAfterEdge",  16'd0);

        // Release reset, then change data with the enable held low.
        waitUntil(35);  rst_n = 1'b1; data = 16'd10;
        waitUntil(60);  checkOutput("holdData10",      16'd0);
        waitUntil(70);  data = 16'd20;
        waitUntil(100); checkOutput("holdData20",      16'd0);
        waitUntil(105); data = 16'd30;
        waitUntil(135); checkOutput("holdData30",      16'd0);

        // Enable loads: the value only appears after the next rising edge.
        waitUntil(140); DFF_enable = 1'b1; data = 16'd40;
        waitUntil(145); checkOutput("noCombPath",      16'd0);
        waitUntil(155); checkOutput("load40",          16'd40);
        waitUntil(175); data = 16'd10;
        waitUntil(180); checkOutput("midCycleData",    16'd40);
        waitUntil(195); checkOutput("load10",          16'd10);

        // Reset applied mid-operation discards the stored value at once.
        waitUntil(210); rst_n = 1'b0; data = 16'd20;
        #1;             checkOutput("asyncReset",      16'd0);
        waitUntil(225); checkOutput("resetHeld",       16'd0);
        waitUntil(235); checkOutput("resetOverEdge",   16'd0);

        // Release reset with the enable high. The first load happens at the
        // following edge.
        waitUntil(245); rst_n = 1'b1; data = 16'd10;
        #1;             checkOutput("releaseNoLoad",   16'd0);
        waitUntil(255); checkOutput("firstLoad",       16'd10);
        waitUntil(275); checkOutput("hold10a",         16'd10);
        waitUntil(295); checkOutput("hold10b",         16'd10);

        // Randomised run. Inputs change on falling edges and the model
        // predicts the value after the next rising edge.
        expOut = 16'd10;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            checkOutput("randCycle", expOut);
            if (!rst_n) begin
                rst_n = 1'b1;
            end else if ($urandom_range(0, 49) == 0) begin
                rst_n  = 1'b0;
                expOut = 16'h0000;
                #1;
                checkOutput("randReset", expOut);
            end
            data       = 16'($urandom);
            DFF_enable = 1'($urandom_range(0, 1));
            if (rst_n && DFF_enable) begin
                expOut = data;
            end
        end
        @(negedge clk);
        checkOutput("randFinal", expOut);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_dff_16b
